product_drain_serializer: RTL and testbench

- Consumer end of the iso-schedule multiplication datapath.
- Takes a one-cycle snapshot of the full DIM_C x DIM_A product array held in the multiplier's output register, then streams it out one product per accepted beat on a valid/ready interface.
- While streaming, it accumulates a per-row sum, so downstream logic gets both the individual products and the row reduction.
- It frees the multiplier's output register one cycle after a load is accepted, so the next schedule can start while the drain runs.

---
 rtl/product_drain_serializer_if.sv | 40 ++++
 rtl/product_drain_serializer.sv | 133 +++++++++++++
 tb/tb_product_drain_serializer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/product_drain_serializer_if.sv
// Handshake bundle between the multiplier output register, the product drain
// serializer and the downstream consumer of products and row sums.
// slave  : the serializer's view (takes the snapshot, drives the stream).
// master : the surrounding logic's view (offers the snapshot, accepts beats).
interface product_drain_serializer_if #(
  parameter int DIM_A     = 8,
  parameter int DIM_C     = 2,
  parameter int ACC_WIDTH = 12,
  parameter int SUM_WIDTH = ACC_WIDTH + $clog2(DIM_A)
);
  localparam int ROW_W = (DIM_C > 1) ? $clog2(DIM_C) : 1;
  localparam int COL_W = (DIM_A > 1) ? $clog2(DIM_A) : 1;

  // Snapshot side
  logic                                        load_valid;
  logic                                        load_ready;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]  prod_in;

  // Stream side
  logic                                        out_valid;
  logic                                        out_ready;
  logic [ACC_WIDTH-1:0]                        out_data;
  logic [ROW_W-1:0]                            out_row;
  logic [COL_W-1:0]                            out_col;
  logic                                        out_last;
  logic [SUM_WIDTH-1:0]                        out_sum;
  logic                                        frame_done;

  modport slave (
    input  load_valid, prod_in, out_ready,
    output load_ready, out_valid, out_data, out_row, out_col,
           out_last, out_sum, frame_done
  );

  modport master (
    output load_valid, prod_in, out_ready,
    input  load_ready, out_valid, out_data, out_row, out_col,
           out_last, out_sum, frame_done
  );
endinterface

// File: rtl/product_drain_serializer.sv
// Product drain serializer: snapshots the DIM_C x DIM_A product array from the
// multiplier output register in one cycle, then streams it row-major, one
// product per accepted beat, alongside a running per-row sum. The bus
// interface must be instantiated with the same parameters as this module.
module product_drain_serializer #(
  parameter int DIM_A     = 8,
  parameter int DIM_C     = 2,
  parameter int ACC_WIDTH = 12,
  parameter int SUM_WIDTH = ACC_WIDTH + $clog2(DIM_A)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  product_drain_serializer_if.slave bus
);
  localparam int ROW_W = (DIM_C > 1) ? $clog2(DIM_C) : 1;
  localparam int COL_W = (DIM_A > 1) ? $clog2(DIM_A) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM_C - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DIM_A - 1);

  typedef enum logic {IDLE, DRAIN} state_t;
  typedef logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_arr_t;

  state_t               state;
  logic                 load_ready_q;
  logic                 out_valid_q;
  logic                 frame_done_q;
  logic [ROW_W-1:0]     row_q;
  logic [COL_W-1:0]     col_q;
  logic [SUM_WIDTH-1:0] acc_q;
  prod_arr_t            snap_p0;

  logic [ACC_WIDTH-1:0] cur_prod;
  logic [SUM_WIDTH-1:0] cur_sum;
  logic                 col_last;
  logic                 row_last;
  logic                 accept;

  // Products are unsigned; widening is a plain zero extension. SUM_WIDTH
  // carries log2(DIM_A) guard bits, so a full row of maximum products fits.
  function automatic logic [SUM_WIDTH-1:0] zext_sum(input logic [ACC_WIDTH-1:0] p);
    return SUM_WIDTH'(p);
  endfunction

  function automatic logic [SUM_WIDTH-1:0] add_sum(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [SUM_WIDTH-1:0] b);
    return a + b;
  endfunction

  // ---- stage p0: snapshot of the multiplier output register ----

  // Capture the whole array on the load handshake; contents are don't-care
  // until the first load, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (load_ready_q && bus.load_valid) begin
      snap_p0 <= bus.prod_in;
    end
  end

  // ---- stream stage: beat selection from registered indices ----

  // Outputs depend only on registered state, so they are stable while stalled.
  // Gating with out_valid_q keeps the stream outputs at zero while idle.
  always_comb begin
    cur_prod = out_valid_q ? snap_p0[row_q][col_q] : '0;
    cur_sum  = add_sum(acc_q, zext_sum(cur_prod));
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);
    accept   = out_valid_q && bus.out_ready;
  end

  // Drain FSM: advances the row/column indices and row accumulator per beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      load_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      acc_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            state        <= DRAIN;
            load_ready_q <= 1'b0;
            out_valid_q  <= 1'b1;
            row_q        <= '0;
            col_q        <= '0;
            acc_q        <= '0;
          end
        end
        DRAIN: begin
          if (accept) begin
            if (col_last) begin
              acc_q <= '0;
              col_q <= '0;
              if (row_last) begin
                // Final beat of the frame: back to IDLE, indices parked at 0.
                row_q        <= '0;
                state        <= IDLE;
                load_ready_q <= 1'b1;
                out_valid_q  <= 1'b0;
                frame_done_q <= 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              acc_q <= cur_sum;
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          load_ready_q <= 1'b1;
          out_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = cur_prod;
  assign bus.out_row    = row_q;
  assign bus.out_col    = col_q;
  assign bus.out_last   = out_valid_q && col_last;
  assign bus.out_sum    = cur_sum;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_product_drain_serializer.sv
// Testbench for product_drain_serializer. A reference model builds the
// expected beat list (row-major products with running row sums) straight from
// the snapshot values; a collector records what the DUT shows each cycle and
// each scenario task compares the recording against the model.
module tb_product_drain_serializer;
  localparam int DIM_A     = 8;
  localparam int DIM_C     = 2;
  localparam int ACC_WIDTH = 12;
  localparam int SUM_WIDTH = ACC_WIDTH + $clog2(DIM_A);
  localparam int ROW_W     = (DIM_C > 1) ? $clog2(DIM_C) : 1;
  localparam int COL_W     = $clog2(DIM_A);
  localparam int BEATS     = DIM_A * DIM_C;

  typedef logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] arr_t;
  typedef struct packed {
    logic [ACC_WIDTH-1:0] d;
    logic [ROW_W-1:0]     r;
    logic [COL_W-1:0]     c;
    logic                 l;
    logic [SUM_WIDTH-1:0] s;
  } beat_t;
  typedef struct {
    logic  v;
    beat_t b;
    logic  lr;
    logic  fd;
    logic  rdy;
    arr_t  pin;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  product_drain_serializer_if #(.DIM_A(DIM_A), .DIM_C(DIM_C), .ACC_WIDTH(ACC_WIDTH)) bus ();

  product_drain_serializer #(.DIM_A(DIM_A), .DIM_C(DIM_C), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    vectors = 0;
  int    miscompares = 0;
  samp_t smp[$];
  beat_t exp_q[$];
  beat_t got[$];
  bit    timed_out;

  // Reference model: row-major walk, running sum restarts at each row.
  function automatic void build_model(input arr_t v);
    exp_q.delete();
    for (int c = 0; c < DIM_C; c++) begin
      int unsigned run = 0;
      for (int a = 0; a < DIM_A; a++) begin
        beat_t b;
        run += v[c][a];
        b.d = v[c][a];
        b.r = ROW_W'(c);
        b.c = COL_W'(a);
        b.l = (a == DIM_A - 1);
        b.s = SUM_WIDTH'(run);
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic arr_t rand_arr();
    arr_t v;
    for (int c = 0; c < DIM_C; c++)
      for (int a = 0; a < DIM_A; a++)
        v[c][a] = ACC_WIDTH'($urandom_range(0, (1 << ACC_WIDTH) - 1));
    return v;
  endfunction

  function automatic arr_t pattern_arr();
    arr_t v;
    for (int c = 0; c < DIM_C; c++)
      for (int a = 0; a < DIM_A; a++)
        v[c][a] = ACC_WIDTH'(16 * c + a);
    return v;
  endfunction

  function automatic string fmt(input beat_t b);
    return $sformatf("d=%0d row=%0d col=%0d last=%0d sum=%0d", b.d, b.r, b.c, b.l, b.s);
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.d = bus.out_data;
    b.r = bus.out_row;
    b.c = bus.out_col;
    b.l = bus.out_last;
    b.s = bus.out_sum;
    return b;
  endfunction

  // Offer a snapshot at this negedge; returns at the next negedge with
  // prod_in scrambled so later changes cannot leak into the stream.
  task automatic do_load(input arr_t v, input bit hold);
    bus.prod_in    = v;
    bus.load_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.load_valid = 1'b0;
    bus.prod_in = rand_arr();
  endtask

  // Record one sample per cycle until frame_done is seen or the budget runs
  // out. stall_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
  // load_mode: 0 load_valid low, 1 high with fresh prod_in each cycle,
  // 2 high with prod_in held. Returns at the negedge showing frame_done.
  task automatic collect(input int stall_mode, input int load_mode, input int max_cycles);
    samp_t s;
    smp.delete();
    got.delete();
    timed_out = 1'b0;
    for (int i = 0; i <= max_cycles; i++) begin
      if (i == max_cycles) begin
        timed_out = 1'b1;
        break;
      end
      case (stall_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (i % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (load_mode == 1) begin
        bus.load_valid = 1'b1;
        bus.prod_in    = rand_arr();
      end else if (load_mode == 2) begin
        bus.load_valid = 1'b1;
      end
      s.v   = bus.out_valid;
      s.b   = cur_beat();
      s.lr  = bus.load_ready;
      s.fd  = bus.frame_done;
      s.rdy = bus.out_ready;
      s.pin = bus.prod_in;
      smp.push_back(s);
      if (s.v === 1'b1 && s.rdy === 1'b1) got.push_back(s.b);
      if (s.fd === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.load_valid = 1'b1;
    bus.prod_in    = rand_arr();
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.out_valid, cur_beat(), bus.frame_done} !== '0 || bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state got valid=%0d %s fd=%0d load_ready=%0d want all 0, load_ready=1",
               bus.out_valid, fmt(cur_beat()), bus.frame_done, bus.load_ready);
    end
    rst_n          = 1'b1;
    bus.load_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle got valid=%0d load_ready=%0d want 0/1", bus.out_valid, bus.load_ready);
    end
  endtask

  task automatic test_single();
    arr_t v = pattern_arr();
    build_model(v);
    do_load(v, 1'b0);
    collect(0, 0, 100);
    vectors++;
    if (smp[0].v !== 1'b1) begin
      miscompares++;
      $display("FAIL single latency got valid=%0d want 1", smp[0].v);
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS) begin
        miscompares++;
        $display("FAIL single extra beat got %s", fmt(got[k]));
      end else if (got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL single beat%0d got %s want %s", k, fmt(got[k]), fmt(exp_q[k]));
      end
    end
    vectors++;
    if (timed_out || got.size() != BEATS || smp.size() != BEATS + 1) begin
      miscompares++;
      $display("FAIL single consecutive beats=%0d cycles=%0d want %0d/%0d", got.size(), smp.size(),
               BEATS, BEATS + 1);
    end
    vectors++;
    if (got.size() < BEATS || got[7].s !== 28 || got[15].s !== 156 || got[7].l !== 1'b1 || got[15].l !== 1'b1) begin
      miscompares++;
      $display("FAIL single row_sums got %s / %s want sum 28 and 156 with last=1",
               fmt(got.size() > 7 ? got[7] : '0), fmt(got.size() > 15 ? got[15] : '0));
    end
    vectors++;
    if (smp[$].fd !== 1'b1 || smp[$].v !== 1'b0 || smp[$].lr !== 1'b1) begin
      miscompares++;
      $display("FAIL single frame_done got fd=%0d valid=%0d load_ready=%0d want 1/0/1",
               smp[$].fd, smp[$].v, smp[$].lr);
    end
  endtask

  task automatic test_max();
    arr_t v = '1;
    build_model(v);
    do_load(v, 1'b0);
    collect(2, 0, 400);
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS || got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL max beat%0d got %s want %s", k, fmt(got[k]), fmt(k < BEATS ? exp_q[k] : '0));
      end
    end
    vectors++;
    if (timed_out || got.size() != BEATS || got[7].s !== 15'h7FF8 || got[15].s !== 15'h7FF8) begin
      miscompares++;
      $display("FAIL max row_sums beats=%0d timeout=%0d want %0d beats, sums 0x7ff8", got.size(),
               timed_out, BEATS);
    end
  endtask

  task automatic test_backpressure();
    arr_t v = pattern_arr();
    build_model(v);
    do_load(v, 1'b0);
    collect(1, 0, 200);
    for (int i = 0; i + 1 < smp.size(); i++) begin
      if (smp[i].v === 1'b1 && smp[i].rdy === 1'b0) begin
        vectors++;
        if (smp[i + 1].v !== 1'b1 || smp[i + 1].b !== smp[i].b) begin
          miscompares++;
          $display("FAIL stall_hold cycle%0d got %s want %s", i + 1, fmt(smp[i + 1].b), fmt(smp[i].b));
        end
      end
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS || got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL backpressure beat%0d got %s want %s", k, fmt(got[k]), fmt(k < BEATS ? exp_q[k] : '0));
      end
    end
    vectors++;
    if (timed_out || got.size() != BEATS || smp[$].fd !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure beat_count got %0d want %0d (timeout=%0d)", got.size(), BEATS, timed_out);
    end
  endtask

  task automatic test_busy_loads();
    arr_t v1 = rand_arr();
    arr_t v2;
    build_model(v1);
    do_load(v1, 1'b1);
    collect(2, 1, 400);
    foreach (smp[i]) begin
      if (smp[i].v === 1'b1) begin
        vectors++;
        if (smp[i].lr !== 1'b0) begin
          miscompares++;
          $display("FAIL busy load_ready cycle%0d got %0d want 0", i, smp[i].lr);
        end
      end
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS || got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL busy beat%0d got %s want %s", k, fmt(got[k]), fmt(k < BEATS ? exp_q[k] : '0));
      end
    end
    vectors++;
    if (timed_out || got.size() != BEATS) begin
      miscompares++;
      $display("FAIL busy beat_count got %0d want %0d (timeout=%0d)", got.size(), BEATS, timed_out);
    end
    // The array driven during the frame_done cycle is the next capture.
    v2 = smp[$].pin;
    build_model(v2);
    @(negedge clk);
    bus.load_valid = 1'b0;
    collect(0, 0, 100);
    vectors++;
    if (smp[0].v !== 1'b1) begin
      miscompares++;
      $display("FAIL busy recapture got valid=%0d want 1", smp[0].v);
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS || got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL busy frame2 beat%0d got %s want %s", k, fmt(got[k]), fmt(k < BEATS ? exp_q[k] : '0));
      end
    end
  endtask

  task automatic test_reset_mid();
    arr_t v = rand_arr();
    do_load(v, 1'b0);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_col !== 3'd5 || bus.out_row !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_position got valid=%0d row=%0d col=%0d want 1/0/5", bus.out_valid,
               bus.out_row, bus.out_col);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.out_valid, cur_beat(), bus.frame_done} !== '0 || bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset got valid=%0d %s fd=%0d load_ready=%0d want all 0, load_ready=1",
               bus.out_valid, fmt(cur_beat()), bus.frame_done, bus.load_ready);
    end
    rst_n = 1'b1;
    v = rand_arr();
    build_model(v);
    do_load(v, 1'b0);
    collect(0, 0, 100);
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS || got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL mid_reload beat%0d got %s want %s", k, fmt(got[k]), fmt(k < BEATS ? exp_q[k] : '0));
      end
    end
    vectors++;
    if (timed_out || got.size() != BEATS) begin
      miscompares++;
      $display("FAIL mid_reload beat_count got %0d want %0d", got.size(), BEATS);
    end
  endtask

  task automatic test_back_to_back();
    arr_t v1 = rand_arr();
    arr_t v2 = rand_arr();
    build_model(v1);
    do_load(v1, 1'b1);
    collect(0, 2, 100);
    vectors++;
    if (timed_out || got.size() != BEATS || smp[$].v !== 1'b0 || smp[$].lr !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b gap_cycle got beats=%0d valid=%0d load_ready=%0d want %0d/0/1",
               got.size(), smp[$].v, smp[$].lr, BEATS);
    end
    bus.prod_in = v2;
    build_model(v2);
    @(negedge clk);
    bus.load_valid = 1'b0;
    collect(0, 0, 100);
    vectors++;
    if (smp[0].v !== 1'b1 || smp[0].b !== exp_q[0]) begin
      miscompares++;
      $display("FAIL b2b frame2_start got valid=%0d %s want 1 %s", smp[0].v, fmt(smp[0].b), fmt(exp_q[0]));
    end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (k >= BEATS || got[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL b2b beat%0d got %s want %s", k, fmt(got[k]), fmt(k < BEATS ? exp_q[k] : '0));
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      arr_t v = rand_arr();
      build_model(v);
      do_load(v, 1'b0);
      collect(2, 0, 400);
      for (int k = 0; k < got.size(); k++) begin
        vectors++;
        if (k >= BEATS || got[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL random f%0d beat%0d got %s want %s", f, k, fmt(got[k]),
                   fmt(k < BEATS ? exp_q[k] : '0));
        end
      end
      vectors++;
      if (timed_out || got.size() != BEATS || smp[$].fd !== 1'b1) begin
        miscompares++;
        $display("FAIL random f%0d beat_count got %0d want %0d (timeout=%0d)", f, got.size(), BEATS, timed_out);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.prod_in    = '0;
    test_reset();
    test_single();
    test_max();
    test_backpressure();
    test_busy_loads();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
